des_round_sequencer: RTL and testbench

Iterative control core for the DES engine. It time-multiplexes one external combinational round unit (expansion, S-box, P, XOR, built from existing round pieces) across all 16 rounds of one 64-bit block. It owns the L/R state register, the C/D key-schedule register with per-round rotation (left for encryption, right for decryption), the round counter and the start/done handshake. It sits between the Initial_Permutation/PC-1 stages and IP_inv, and replaces the unrolled round chains with one round unit driven for 16 cycles.

---
 rtl/des_round_sequencer.sv | 138 +++++++++++++
 tb/tb_des_round_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_sequencer.sv
// des_round_sequencer: iterative DES round controller.
// Drives one external combinational round unit for 16 cycles per 64-bit block.
// Owns the L/R state, the C/D key-schedule register with per-round rotation,
// the round counter and the START/DONE handshake.
// Bit 1 of the DES numbering maps to the MSB of each vector.
// Ports:
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   START, MODE       block request; MODE 0 = encrypt, 1 = decrypt (sampled with START)
//   BLOCK_IN          block after IP, {L0, R0}
//   KEY_IN            key after PC-1, {C0, D0}
//   ROUND_IN          round unit result {L_i, R_i}
//   LR_OUT, CD_OUT    current L/R and rotated C/D fed to the round unit / PC-2
//   ROUND_CNT         current round minus 1, 0 when not running
//   BUSY, DONE        rounds executing / one-cycle result-valid pulse
//   BLOCK_OUT         {R16, L16} for IP_inv, held until the next completion
module des_round_sequencer (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        MODE,
  input  logic [63:0] BLOCK_IN,
  input  logic [55:0] KEY_IN,
  input  logic [63:0] ROUND_IN,
  output logic [63:0] LR_OUT,
  output logic [55:0] CD_OUT,
  output logic [3:0]  ROUND_CNT,
  output logic        BUSY,
  output logic        DONE,
  output logic [63:0] BLOCK_OUT
);

  localparam int unsigned HALF_W = 28;
  localparam int unsigned KEY_W  = 56;
  localparam int unsigned BLK_W  = 64;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(15);

  // Rotate one 28-bit half by 1 or 2 positions; "left" moves bits toward bit 1 (MSB).
  function automatic logic [HALF_W-1:0] rot_half(input logic [HALF_W-1:0] h,
                                                 input logic right, input logic two);
    logic [HALF_W-1:0] r;
    if (right) r = two ? {h[1:0], h[HALF_W-1:2]} : {h[0], h[HALF_W-1:1]};
    else       r = two ? {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]} : {h[HALF_W-2:0], h[HALF_W-1]};
    return r;
  endfunction

  // Rotate C and D independently.
  function automatic logic [KEY_W-1:0] rot_cd(input logic [KEY_W-1:0] cd,
                                              input logic right, input logic two);
    return {rot_half(cd[KEY_W-1:HALF_W], right, two), rot_half(cd[HALF_W-1:0], right, two)};
  endfunction

  logic [1:0]       state, state_d;
  logic             mode_q, mode_d;
  logic [BLK_W-1:0] lr_q, lr_d;
  logic [KEY_W-1:0] cd_q, cd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             busy_q, done_q;
  logic             single_shift;

  // Step into the next round uses a 1-position shift after cnt 0, 7 and 14 in both
  // directions (the decrypt schedule is the encrypt one read backwards).
  assign single_shift = (cnt_q == CNT_W'(0)) || (cnt_q == CNT_W'(7)) || (cnt_q == CNT_W'(14));

  // Next-state and datapath updates.
  always_comb begin
    state_d = state;
    mode_d  = mode_q;
    lr_d    = lr_q;
    cd_d    = cd_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          mode_d  = MODE;
          lr_d    = BLOCK_IN;
          // Encrypt round 1 uses K rotated left by 1; decrypt round 1 uses K unrotated (K16).
          cd_d    = MODE ? KEY_IN : rot_cd(KEY_IN, 1'b0, 1'b0);
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (state == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        lr_d = ROUND_IN;
        if (cnt_q == LAST_CNT) begin
          // Pre-output swap: {R16, L16}; CD left as-is after the last round.
          blk_d   = {ROUND_IN[31:0], ROUND_IN[63:32]};
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cd_d  = rot_cd(cd_q, mode_q, ~single_shift);
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; BUSY/DONE registered from the next state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      mode_q <= 1'b0;
      lr_q   <= '0;
      cd_q   <= '0;
      cnt_q  <= '0;
      blk_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      mode_q <= mode_d;
      lr_q   <= lr_d;
      cd_q   <= cd_d;
      cnt_q  <= cnt_d;
      blk_q  <= blk_d;
      busy_q <= (state_d == S_RUN);
      done_q <= (state_d == S_DONE);
    end
  end

  assign LR_OUT    = lr_q;
  assign CD_OUT    = cd_q;
  assign ROUND_CNT = cnt_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign BLOCK_OUT = blk_q;

endmodule

// File: tb/tb_des_round_sequencer.sv
// tb_des_round_sequencer: directed bench for des_round_sequencer.
// Supplies a full DES round unit (E, S-boxes, P, PC-2) plus IP/IP_inv/PC-1 around the DUT.
module tb_des_round_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [63:0] block_in = '0;
  logic [55:0] key_in = '0;
  logic [63:0] round_in;
  logic [63:0] lr_out;
  logic [55:0] cd_out;
  logic [3:0]  round_cnt;
  logic        busy;
  logic        done;
  logic [63:0] block_out;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int IPI_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
                              28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int SBOX [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // Cumulative rotation of C/D per round (rounds 1..16).
  localparam int ENC_CUM [16] = '{1,2,4,6,8,10,12,14,15,17,19,21,23,25,27,28};
  localparam int DEC_CUM [16] = '{0,1,3,5,7,9,11,13,14,16,18,20,22,24,26,27};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[63-i] = x[64-IP_T[i]];
    return r;
  endfunction

  function automatic logic [63:0] ip_inv(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[63-i] = x[64-IPI_T[i]];
    return r;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55-i] = x[64-PC1_T[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47-i] = x[56-PC2_T[i]];
    return r;
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] x);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47-i] = x[32-E_T[i]];
    return r;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = x[32-P_T[i]];
    return r;
  endfunction

  function automatic logic [31:0] f_fn(input logic [31:0] rr, input logic [47:0] k);
    logic [47:0] x;
    logic [5:0]  six;
    logic [31:0] s;
    int          v;
    x = e_exp(rr) ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      v = SBOX[b*64 + 32*int'(six[5]) + 16*int'(six[0]) + int'(six[4:1])];
      s[31-4*b -: 4] = 4'(v);
    end
    return p_perm(s);
  endfunction

  // Rotate a 28-bit half left by n (0..28).
  function automatic logic [27:0] rl(input logic [27:0] h, input int n);
    logic [55:0] t;
    t = {h, h};
    return t[55-n -: 28];
  endfunction

  function automatic logic [55:0] rl_cd(input logic [55:0] cd, input int n);
    return {rl(cd[55:28], n), rl(cd[27:0], n)};
  endfunction

  // External round unit: {L_i, R_i} = {R, L ^ f(R, PC-2(CD))}.
  always_comb round_in = {lr_out[31:0], lr_out[63:32] ^ f_fn(lr_out[31:0], pc2(cd_out))};

  des_round_sequencer dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .MODE(mode),
    .BLOCK_IN(block_in), .KEY_IN(key_in), .ROUND_IN(round_in),
    .LR_OUT(lr_out), .CD_OUT(cd_out), .ROUND_CNT(round_cnt),
    .BUSY(busy), .DONE(done), .BLOCK_OUT(block_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lr"}, lr_out, 64'h0);
    check({tag, "_cd"}, 64'(cd_out), 64'h0);
    check({tag, "_cnt"}, 64'(round_cnt), 64'h0);
    check({tag, "_busy"}, 64'(busy), 64'h0);
    check({tag, "_done"}, 64'(done), 64'h0);
    check({tag, "_blk"}, block_out, 64'h0);
  endtask

  // Called at a falling edge; returns at the falling edge after the START edge.
  task automatic start_block(input logic m, input logic [63:0] blk, input logic [55:0] k);
    start = 1'b1; mode = m; block_in = blk; key_in = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for DONE; the number of falling edges waited must equal exp_n.
  task automatic wait_done(input string tag, input int exp_n);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [27:0] h;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS encrypt with per-round handshake trace
    start_block(1'b0, ip(PT), pc1(KEY));
    for (int r = 1; r <= 16; r++) begin
      check("enc_cnt", 64'(round_cnt), 64'(r - 1));
      check("enc_busy", 64'(busy), 64'h1);
      check("enc_nodone", 64'(done), 64'h0);
      @(negedge clk);
    end
    check("enc_done", 64'(done), 64'h1);
    check("enc_busy_low", 64'(busy), 64'h0);
    check("enc_result", ip_inv(block_out), CT);
    check("enc_final_cd", 64'(cd_out), 64'(pc1(KEY)));
    check("enc_cnt_zero", 64'(round_cnt), 64'h0);
    @(negedge clk);
    check("enc_done_pulse", 64'(done), 64'h0);
    check("enc_idle_busy", 64'(busy), 64'h0);

    // FIPS decrypt
    start_block(1'b1, ip(CT), pc1(KEY));
    wait_done("dec", 16);
    check("dec_result", ip_inv(block_out), PT);
    check("dec_final_cd", 64'(cd_out), 64'(rl_cd(pc1(KEY), 1)));
    @(negedge clk);

    // Rotation trace, encrypt then decrypt
    start_block(1'b0, 64'h0, 56'h80000008000000);
    for (int r = 1; r <= 16; r++) begin
      h = rl(28'h8000000, ENC_CUM[r-1]);
      check("rot_enc_cd", 64'(cd_out), 64'({h, h}));
      @(negedge clk);
    end
    check("rot_enc_done", 64'(done), 64'h1);
    check("rot_enc_final", 64'(cd_out), 64'(56'h80000008000000));
    @(negedge clk);
    start_block(1'b1, 64'h0, 56'h80000008000000);
    for (int r = 1; r <= 16; r++) begin
      h = rl(28'h8000000, 28 - DEC_CUM[r-1]);
      check("rot_dec_cd", 64'(cd_out), 64'({h, h}));
      @(negedge clk);
    end
    check("rot_dec_done", 64'(done), 64'h1);
    check("rot_dec_final", 64'(cd_out), 64'(56'h00000010000001));
    @(negedge clk);

    // START during RUN (round 5, other MODE and data) is ignored
    start_block(1'b0, ip(PT), pc1(KEY));
    repeat (4) @(negedge clk);
    check("ign_cnt", 64'(round_cnt), 64'h4);
    start = 1'b1; mode = 1'b1; block_in = 64'hFFFF0000FFFF0000; key_in = '0;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", 11);
    check("ign_result", ip_inv(block_out), CT);
    check("ign_final_cd", 64'(cd_out), 64'(pc1(KEY)));
    @(negedge clk);

    // START held high: DONE every 17 cycles, BUSY low only in the DONE cycle
    start = 1'b1; mode = 1'b0; block_in = ip(PT); key_in = pc1(KEY);
    for (int k = 1; k <= 52; k++) begin
      @(negedge clk);
      check("b2b_done", 64'(done), 64'((k % 17) == 0));
      check("b2b_busy", 64'(busy), 64'((k % 17) != 0));
      if ((k % 17) == 0) check("b2b_result", ip_inv(block_out), CT);
    end
    start = 1'b0;
    wait_done("b2b_tail", 16);
    @(negedge clk);

    // Asynchronous reset during round 9
    start_block(1'b0, ip(PT), pc1(KEY));
    repeat (8) @(negedge clk);
    check("rst_cnt_before", 64'(round_cnt), 64'h8);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_after_done", 64'(done), 64'h0);
      check("rst_after_busy", 64'(busy), 64'h0);
      check("rst_after_blk", block_out, 64'h0);
    end
    start_block(1'b0, ip(PT), pc1(KEY));
    wait_done("rst_restart", 16);
    check("rst_restart_result", ip_inv(block_out), CT);

    // Idle stability for 50 cycles
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("idle_blk", ip_inv(block_out), CT);
      check("idle_done", 64'(done), 64'h0);
      check("idle_cnt", 64'(round_cnt), 64'h0);
      check("idle_busy", 64'(busy), 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
